// File: rtl/load_store_unit.sv
// Load/store unit with IDLE -> ACCESS -> RESP sequencing; all outputs are registered.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned H/HU/W requests into byte accesses.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SplitEn = 1'b1;
`else
    localparam logic SplitEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_ctrl_q, mem_ctrl_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        we_q, we_d;
    logic        split_q, split_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] asm_q, asm_d;

    logic        bad_ctrl;
    logic        misal;
    logic [1:0]  cnt_inc;
    logic [31:0] wdata_shift;
    logic [31:0] asm_next;
    logic [31:0] split_result;

    assign bad_ctrl = (req_ctrl == 3'b011) || (req_ctrl[2:1] == 2'b11) ||
                      (req_we && req_ctrl[2]);
    assign misal    = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_ctrl == 3'b010) && (req_addr[1:0] != 2'b00));

    assign cnt_inc     = cnt_q + 2'd1;
    assign wdata_shift = wdata_q >> {cnt_inc, 3'b000};
    // Byte i of a split load lands in lane i of the assembly buffer.
    assign asm_next    = asm_q | ({24'b0, mem_rdata[7:0]} << {cnt_q, 3'b000});

    always_comb begin
        split_result = asm_next;
        unique case (ctrl_q)
            3'b001:  split_result = {{16{asm_next[15]}}, asm_next[15:0]};
            3'b101:  split_result = {16'b0, asm_next[15:0]};
            default: split_result = asm_next;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'b0;
        mem_addr_d   = 32'b0;
        mem_wdata_d  = 32'b0;
        mem_we_d     = 1'b0;
        mem_ctrl_d   = 3'b000;
        wdata_d      = wdata_q;
        ctrl_d       = ctrl_q;
        we_d         = we_q;
        split_d      = split_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        asm_d        = asm_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    wdata_d = req_wdata;
                    ctrl_d  = req_ctrl;
                    we_d    = req_we;
                    split_d = misal;
                    cnt_d   = 2'd0;
                    last_d  = (req_ctrl[1:0] == 2'b01) ? 2'd1 : 2'd3;
                    asm_d   = 32'b0;
                    if (bad_ctrl || (misal && !SplitEn)) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = StAccess;
                        mem_addr_d = req_addr;
                        mem_we_d   = req_we;
                        if (misal) begin
                            mem_ctrl_d  = req_we ? 3'b000 : 3'b100;
                            mem_wdata_d = {24'b0, req_wdata[7:0]};
                        end else begin
                            mem_ctrl_d  = req_ctrl;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            StAccess: begin
                if (!split_q) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'b0 : mem_rdata;
                end else begin
                    asm_d = we_q ? 32'b0 : asm_next;
                    if (cnt_q == last_q) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? 32'b0 : split_result;
                    end else begin
                        cnt_d       = cnt_inc;
                        mem_addr_d  = mem_addr_q + 32'd1;
                        mem_we_d    = we_q;
                        mem_ctrl_d  = mem_ctrl_q;
                        mem_wdata_d = {24'b0, wdata_shift[7:0]};
                    end
                end
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            mem_we_q     <= 1'b0;
            mem_ctrl_q   <= 3'b000;
            wdata_q      <= 32'b0;
            ctrl_q       <= 3'b000;
            we_q         <= 1'b0;
            split_q      <= 1'b0;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            asm_q        <= 32'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_ctrl_q   <= mem_ctrl_d;
            wdata_q      <= wdata_d;
            ctrl_q       <= ctrl_d;
            we_q         <= we_d;
            split_q      <= split_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            asm_q        <= asm_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_ctrl   = mem_ctrl_q;

endmodule
